// File: rtl/weight_fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// weight_fetch_sequencer_if
//
// Weight stream handshake between the fetch sequencer (master) and the
// consuming MAC array (slave). A word moves when w_valid and w_ready are both
// high on the same rising edge.
//
// Signals:
//   w_data  [DW]  weight word
//   w_idx   [AW]  row index of w_data
//   w_valid       w_data/w_idx/w_last are meaningful
//   w_ready       consumer accepts the word this cycle
//   w_last        current word is the final word of the row
// -----------------------------------------------------------------------------
interface weight_fetch_sequencer_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic [DW-1:0] w_data;
  logic [AW-1:0] w_idx;
  logic          w_valid;
  logic          w_ready;
  logic          w_last;

  modport master (output w_data, output w_idx, output w_valid, output w_last,
                  input  w_ready);
  modport slave  (input  w_data, input  w_idx, input  w_valid, input  w_last,
                  output w_ready);
endinterface

// File: rtl/weight_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// weight_fetch_sequencer
//
// Streams one neuron row of DEPTH weight words out of a single-port BRAM. In
// IDLE the BRAM port is lent to the weight loader (wr_*); a start pulse claims
// it, reads addresses 0..DEPTH-1 and pushes each word through a 2-entry skid
// buffer onto the w_stream handshake. The row ends with a one-cycle done pulse.
//
// The BRAM samples its inputs on the falling edge, so a read presented during
// cycle k has bram_do valid at the rising edge closing cycle k; the word is
// captured into the buffer on that same edge.
//
// Parameters: DEPTH words per row, AW BRAM address width, DW word width.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   start / busy / done  row fetch control and status
//   wr_req/addr/data/ack weight load port, served only in IDLE
//   bram_*               single-port BRAM master
//   w_stream             weight stream (weight_fetch_sequencer_if.master)
//   checksum             modulo-2^DW sum of words streamed in the current row,
//                        present only when WFS_CHECKSUM_EN is defined
// -----------------------------------------------------------------------------
module weight_fetch_sequencer #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      start,
  output logic                      busy,
  output logic                      done,

  input  logic                      wr_req,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DW-1:0]             wr_data,
  output logic                      wr_ack,

  output logic [AW-1:0]             bram_addr,
  output logic [DW-1:0]             bram_di,
  output logic                      bram_en,
  output logic                      bram_we,
  input  logic [DW-1:0]             bram_do,

  weight_fetch_sequencer_if.master  w_stream
`ifdef WFS_CHECKSUM_EN
  ,
  output logic [DW-1:0]             checksum
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } entry_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q;
  entry_t        head_q, tail_q;   // head_q drives the stream outputs
  logic [1:0]    occ_q;            // buffered words, 0..2
  entry_t        rd_entry;
  logic          rd_issue;
  logic          start_acc;
  logic          pop;

  assign pop      = w_stream.w_valid & w_stream.w_ready;
  assign rd_entry = '{idx: ptr_q, data: bram_do};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next state and BRAM port arbitration
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    rd_issue  = 1'b0;
    wr_ack    = 1'b0;
    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_di   = '0;

    // Everything that would touch the BRAM or acknowledge a load is held
    // off while reset is applied.
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            // A start beats a simultaneous load; the loader keeps wr_req up.
            start_acc = 1'b1;
            state_d   = FETCH;
          end else if (wr_req) begin
            wr_ack = 1'b1;
            // Out-of-row addresses are acknowledged but never reach the BRAM.
            if ({1'b0, wr_addr} < DEPTH_X) begin
              bram_en   = 1'b1;
              bram_we   = 1'b1;
              bram_addr = wr_addr;
              bram_di   = wr_data;
            end
          end
        end
        FETCH: begin
          // A read lands in the buffer on the edge that ends its issue cycle,
          // so nothing is in flight when this decision is made and the
          // buffer occupancy alone bounds the outstanding words.
          if (occ_q < 2'd2) begin
            rd_issue  = 1'b1;
            bram_en   = 1'b1;
            bram_addr = ptr_q;
            if (ptr_q == LAST_IDX) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (pop && w_stream.w_last) state_d = FIN;
        end
        FIN: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read pointer and 2-entry output buffer
  // ---------------------------------------------------------------------------
  // NOTE: the buffer entries are reset (unlike a RAM) because they drive
  // w_data/w_idx directly and must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      // The pointer parks on the last address instead of wrapping.
      if (start_acc)                         ptr_q <= '0;
      else if (rd_issue && ptr_q != LAST_IDX) ptr_q <= ptr_q + AW'(1);

      // Head only changes on a pop or when filling an empty buffer, which
      // keeps w_data/w_idx stable across a stall.
      case ({rd_issue, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= rd_entry;
          else               tail_q <= rd_entry;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_q <= rd_entry;
          end else begin
            head_q <= tail_q;
            tail_q <= rd_entry;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == FIN);
  assign w_stream.w_valid = (occ_q != 2'd0);
  assign w_stream.w_data  = head_q.data;
  assign w_stream.w_idx   = head_q.idx;
  assign w_stream.w_last  = w_stream.w_valid && (head_q.idx == LAST_IDX);

`ifdef WFS_CHECKSUM_EN
  // Running sum of transferred words; frozen between DONE and the next start.
  logic [DW-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (!rst_n)         checksum_q <= '0;
    else if (start_acc) checksum_q <= '0;
    else if (pop)       checksum_q <= checksum_q + head_q.data;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_weight_fetch_sequencer
//
// Self-checking bench for weight_fetch_sequencer. A behavioural BRAM answers
// the DUT's port; a reference row image (model[]) holds the expected weights
// and is updated whenever the bench's own write is guaranteed to be served.
// Each row is checked for read order, buffer bound, word order/content,
// w_last, done timing and load-port blocking. Define WFS_CHECKSUM_EN to also
// check the checksum output.
// -----------------------------------------------------------------------------
module tb_weight_fetch_sequencer;

  localparam int DEPTH      = 28;
  localparam int AW         = 5;
  localparam int DW         = 16;
  localparam int ROW_BUDGET = 400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_di;
  logic          bram_en;
  logic          bram_we;
  logic [DW-1:0] bram_do;
`ifdef WFS_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  weight_fetch_sequencer_if #(.AW(AW), .DW(DW)) ws ();

  weight_fetch_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .bram_addr (bram_addr),
    .bram_di   (bram_di),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_do   (bram_do),
    .w_stream  (ws)
`ifdef WFS_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Falling-edge BRAM: data read in a cycle is valid at the next rising edge.
  logic [DW-1:0] ram [2**AW];
  always @(negedge clk) begin
    if (bram_en) begin
      if (bram_we) ram[bram_addr] <= bram_di;
      else         bram_do        <= ram[bram_addr];
    end
  end

  // Reference row image.
  logic [DW-1:0] model [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_busy"},      busy,       0);
    check({pfx, "_done"},      done,       0);
    check({pfx, "_wr_ack"},    wr_ack,     0);
    check({pfx, "_bram_en"},   bram_en,    0);
    check({pfx, "_bram_we"},   bram_we,    0);
    check({pfx, "_bram_addr"}, bram_addr,  0);
    check({pfx, "_bram_di"},   bram_di,    0);
    check({pfx, "_w_valid"},   ws.w_valid, 0);
    check({pfx, "_w_last"},    ws.w_last,  0);
    check({pfx, "_w_data"},    ws.w_data,  0);
    check({pfx, "_w_idx"},     ws.w_idx,   0);
  endtask

  // One load-port write in IDLE: acknowledged in the same cycle.
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    check("wr_ack", wr_ack, 1);
    check("wr_bram_en", bram_en, int'(a) < DEPTH);
    if (int'(a) < DEPTH) begin
      check("wr_bram_we",   bram_we,   1);
      check("wr_bram_addr", bram_addr, a);
      check("wr_bram_di",   bram_di,   d);
      model[a] = d;
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  // Runs one row. mode 0: ready always high; 1: ready 1,0,0,1 repeating;
  // 2: random ready. abort_at >= 0 stops after that index transfers.
  // with_wr raises a load request at cycle wr_c (cycle 0 is the start cycle).
  task automatic run_row(input int mode, input int abort_at, input bit with_wr,
                         input int wr_c, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, output bit aborted);
    int  c;
    int  exp_idx;
    int  reads;
    int  last_c;
    bit  fin;
    bit  wr_pending;
`ifdef WFS_CHECKSUM_EN
    logic [DW-1:0] exp_sum;
    exp_sum = '0;
    for (int i = 0; i < DEPTH; i++) exp_sum = exp_sum + model[i];
`endif
    c = 0; exp_idx = 0; reads = 0; last_c = -1; fin = 0; wr_pending = 0; aborted = 0;
    while (!fin && !aborted && c < ROW_BUDGET) begin
      @(posedge clk); #1;
      start = (c == 0);
      if (with_wr && c == wr_c) begin
        wr_req = 1'b1; wr_addr = wa; wr_data = wd; wr_pending = 1;
      end
      case (mode)
        0:       ws.w_ready = 1'b1;
        1:       ws.w_ready = (c % 4 == 0) || (c % 4 == 3);
        default: ws.w_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (c == 0) check("busy_at_start", busy, 0);
      if (c == 1) check("busy_in_fetch", busy, 1);
`ifdef WFS_CHECKSUM_EN
      if (c == 1) check("checksum_cleared", checksum, 0);
`endif
      if (wr_pending) check("wr_ack_while_busy", wr_ack, 0);
      check("no_write_while_busy", bram_we, 0);
      check("done_timing", done, last_c >= 0 && c == last_c + 1);
      if (last_c >= 0 && c == last_c + 1) begin
        fin = 1;
`ifdef WFS_CHECKSUM_EN
        check("checksum_at_done", checksum, exp_sum);
`endif
      end
      if (bram_en) begin
        check("rd_addr_order", bram_addr, reads);
        reads++;
      end
      check("outstanding_le_2", (reads - exp_idx) <= 2, 1);
      if (ws.w_valid) begin
        if (exp_idx < DEPTH) begin
          check("w_idx",  ws.w_idx,  exp_idx);
          check("w_data", ws.w_data, model[exp_idx]);
          check("w_last", ws.w_last, exp_idx == DEPTH - 1);
        end else begin
          check("extra_word", ws.w_valid, 0);
        end
      end
      if (ws.w_valid && ws.w_ready) begin
        if (mode == 0) check("stream_cycle", c, exp_idx + 2);
        if (exp_idx == DEPTH - 1) last_c = c;
        if (exp_idx == abort_at)  aborted = 1;
        exp_idx++;
      end
      c++;
    end
    if (!aborted) check("row_finished", fin, 1);
    if (fin) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("done_one_cycle",  done, 0);
      if (wr_pending) begin
        check("wr_ack_after_done", wr_ack, 1);
        check("wr_en_after_done",  bram_en, int'(wa) < DEPTH);
        if (int'(wa) < DEPTH) model[wa] = wd;
        @(posedge clk); #1;
        wr_req = 1'b0;
      end
    end
  endtask

  initial begin
    bit            ab;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    rst_n = 1'b0; start = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    ws.w_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Preload word i = 0x0100 + i, plus an out-of-row write that must not land.
    for (int i = 0; i < DEPTH; i++) write_word(AW'(i), DW'(16'h0100 + i));
    write_word(AW'(30), 16'hDEAD);

    // Full-rate row.
    run_row(0, -1, 0, 0, '0, '0, ab);
    // Stalled row, ready 1,0,0,1.
    run_row(1, -1, 0, 0, '0, '0, ab);

    // Load request during FETCH waits for IDLE; next row sees 0xBEEF at idx 3.
    run_row(0, -1, 1, 5, AW'(3), 16'hBEEF, ab);
    check("beef_in_model", model[3], 16'hBEEF);
    run_row(0, -1, 0, 0, '0, '0, ab);

    // Start and load together: start wins, write served after the row.
    run_row(0, -1, 1, 0, AW'(7), 16'h7A5C, ab);
    run_row(1, -1, 0, 0, '0, '0, ab);

    // Reset for one cycle right after idx 10 transfers.
    run_row(0, 10, 0, 0, '0, '0, ab);
    check("row_aborted", ab, 1);
    @(posedge clk); #1;
    rst_n = 1'b0; ws.w_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; ws.w_ready = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_done_after_reset",  done,       0);
      check("no_valid_after_reset", ws.w_valid, 0);
    end
    run_row(0, -1, 0, 0, '0, '0, ab);

    // Randomized loads, ready patterns and mid-row load requests.
    for (int r = 0; r < 5; r++) begin
      int nw;
      nw = $urandom_range(1, 5);
      for (int k = 0; k < nw; k++) begin
        ra = AW'($urandom_range(0, 2**AW - 1));
        rd = DW'($urandom);
        write_word(ra, rd);
      end
      ra = AW'($urandom_range(0, 2**AW - 1));
      rd = DW'($urandom);
      run_row(2, -1, 1'($urandom_range(0, 1)), $urandom_range(0, 30), ra, rd, ab);
    end

`ifdef WFS_CHECKSUM_EN
    // All words 0x1000: 28 x 0x1000 = 0x1C000, truncated to 0xC000.
    for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 16'h1000);
    run_row(0, -1, 0, 0, '0, '0, ab);
    check("checksum_c000", checksum, 16'hC000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
